// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a byte-serial program image,
// assembles little-endian words, writes them into instruction memory and
// holds the core in reset until the whole image has been written.
module imem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  localparam int          BPW    = DATA_WIDTH / 8;
  localparam int          BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    DONE,
    ERR
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [7:0]            len_lo;
  logic [15:0]           words_left;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [BIDX_W-1:0]     byte_idx;
  logic [DATA_WIDTH-1:0] word_buf;

  logic                  xfer;
  logic                  last_byte;
  logic [15:0]           hdr_n;
  logic [DATA_WIDTH-1:0] word_merged;

  // State register; reset always restarts at the header low byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LEN0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, byte handshake and the word with the incoming byte merged in.
  always_comb begin
    state_next  = state;
    byte_ready  = 1'b0;
    xfer        = 1'b0;
    last_byte   = (byte_idx == BIDX_W'(BPW - 1));
    hdr_n       = {byte_data, len_lo};
    word_merged = word_buf;
    word_merged[8*int'(byte_idx) +: 8] = byte_data;
    err         = (state == ERR);

    case (state)
      LEN0: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = LEN1;
      end
      LEN1: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (hdr_n == 16'd0)                state_next = DONE;
          else if (32'(hdr_n) > DEPTH)       state_next = ERR;
          else                               state_next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        // The write of the final word and the move to DONE share one edge.
        if (byte_valid && last_byte && (words_left == 16'd1)) state_next = DONE;
      end
      DONE, ERR: begin
        if (load_req) state_next = LEN0;
      end
      default: state_next = LEN0;
    endcase

    xfer = byte_valid && byte_ready;
  end

  // Header capture, word assembly, memory write strobe and core reset control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo     <= '0;
      words_left <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;

      // The core is released one edge after DONE is entered, so core_rst
      // stays high through the final write cycle.
      if ((state == DONE) && !load_req) begin
        core_rst <= 1'b0;
        done     <= 1'b1;
      end else begin
        core_rst <= 1'b1;
        done     <= 1'b0;
      end

      case (state)
        LEN0: begin
          if (xfer) len_lo <= byte_data;
        end
        LEN1: begin
          if (xfer && (state_next == DATA)) begin
            words_left <= hdr_n;
            word_idx   <= '0;
            byte_idx   <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            word_buf <= word_merged;
            if (last_byte) begin
              byte_idx   <= '0;
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= word_merged;
              word_idx   <= ADDR_WIDTH'(word_idx + 1);
              words_left <= 16'(words_left - 1);
            end else begin
              byte_idx <= BIDX_W'(byte_idx + 1);
            end
          end
        end
        DONE, ERR: begin
          // A reload restarts counting; memory contents are left untouched.
          if (load_req) begin
            len_lo     <= '0;
            words_left <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed byte images, expected memory writes
// queued by the stimulus and consumed by an independent write monitor.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        load_req;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(w.addr));
        check("wr_data", imem_wdata, w.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for exactly one edge; the loader never stalls in a load state.
  task automatic send_byte(input logic [7:0] b);
    check("byte_ready_before_xfer", 32'(byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load();
    byte_valid = 1'b0;
    load_req   = 1'b1;
    tick();
    load_req   = 1'b0;
  endtask

  // Bounded wait for all queued writes to be observed.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    load_req   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_imem_we",   32'(imem_we),    32'd0);
    check("rst_imem_addr", 32'(imem_addr),  32'd0);
    check("rst_imem_wdata", imem_wdata,     32'd0);
    check("rst_core_rst",  32'(core_rst),   32'd1);
    check("rst_done",      32'(done),       32'd0);
    check("rst_err",       32'(err),        32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd1);

    // Two-word image, back-to-back bytes
    push_wr(8'd0, 32'h12345678);
    push_wr(8'd1, 32'hDEADBEEF);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    byte_valid = 1'b0;
    check("t1_last_we",          32'(imem_we),  32'd1);
    check("t1_core_rst_in_write", 32'(core_rst), 32'd1);
    check("t1_done_in_write",    32'(done),     32'd0);
    tick();
    check("t1_core_rst_released", 32'(core_rst),  32'd0);
    check("t1_done",             32'(done),       32'd1);
    check("t1_ready_in_done",    32'(byte_ready), 32'd0);
    drain("t1_writes_seen");

    // Zero-length image
    pulse_load();
    check("t2_reload_core_rst", 32'(core_rst),   32'd1);
    check("t2_reload_done",     32'(done),       32'd0);
    check("t2_reload_ready",    32'(byte_ready), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    check("t2_ready_done_entered", 32'(byte_ready), 32'd0);
    check("t2_done_not_yet",       32'(done),       32'd0);
    check("t2_core_rst_not_yet",   32'(core_rst),   32'd1);
    tick();
    check("t2_done",     32'(done),     32'd1);
    check("t2_core_rst", 32'(core_rst), 32'd0);

    // Oversized header (257 words)
    pulse_load();
    send_byte(8'h01); send_byte(8'h01);
    byte_valid = 1'b0;
    check("t3_err",        32'(err),        32'd1);
    check("t3_ready",      32'(byte_ready), 32'd0);
    check("t3_core_rst",   32'(core_rst),   32'd1);
    idle(3);
    check("t3_err_held",      32'(err),      32'd1);
    check("t3_core_rst_held", 32'(core_rst), 32'd1);
    check("t3_done_low",      32'(done),     32'd0);
    pulse_load();
    check("t3_err_cleared", 32'(err),        32'd0);
    check("t3_ready_back",  32'(byte_ready), 32'd1);

    // One word with gaps between bytes; load_req mid-load must be ignored
    push_wr(8'd0, 32'hD4C3B2A1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA1);
    byte_valid = 1'b0; byte_data = 8'hFF; tick();
    send_byte(8'hB2);
    byte_valid = 1'b0; byte_data = 8'hEE; load_req = 1'b1; tick(); load_req = 1'b0;
    check("t4_load_req_ignored", 32'(byte_ready), 32'd1);
    send_byte(8'hC3);
    byte_valid = 1'b0; byte_data = 8'hDD; tick();
    check("t4_no_early_write", 32'(exp_q.size()), 32'd1);
    send_byte(8'hD4);
    byte_valid = 1'b0;
    tick();
    check("t4_done", 32'(done), 32'd1);
    drain("t4_writes_seen");

    // Reset in the middle of a word, then resend
    pulse_load();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    byte_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("t5_rst_we",       32'(imem_we),    32'd0);
    check("t5_rst_core_rst", 32'(core_rst),   32'd1);
    rst = 1'b1;
    tick();
    check("t5_after_rst_ready", 32'(byte_ready), 32'd1);
    check("t5_after_rst_addr",  32'(imem_addr),  32'd0);
    check("t5_after_rst_wdata", imem_wdata,      32'd0);
    push_wr(8'd0, 32'h44332211);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    byte_valid = 1'b0;
    tick();
    check("t5_done", 32'(done), 32'd1);
    drain("t5_writes_seen");

    // Bytes held in DONE are refused; reload overwrites address 0
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_ready_refused", 32'(byte_ready), 32'd0);
    end
    check("t6_addr_hold",  32'(imem_addr), 32'd0);
    check("t6_wdata_hold", imem_wdata,     32'h44332211);
    pulse_load();
    check("t6_core_rst_reasserted", 32'(core_rst), 32'd1);
    check("t6_done_cleared",        32'(done),     32'd0);
    push_wr(8'd0, 32'h0BADF00D);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
    byte_valid = 1'b0;
    tick();
    check("t6_done",     32'(done),     32'd1);
    check("t6_core_rst", 32'(core_rst), 32'd0);
    drain("t6_writes_seen");

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
